// File: rtl/control_unit_fft_iter_lat_if.sv
// Control/status bundle between the FFT sequencer and its surroundings.
// slave = sequencer side, master = side that issues START and watches strobes.
interface control_unit_fft_iter_lat_if #(
    parameter int LayWL  = 4,
    parameter int ButtWL = 9
);
    logic              EN;
    logic              START;
    logic [LayWL-1:0]  N_LAY;
    logic              BUSY;
    logic              DONE;
    logic              ERR;
    logic              BUT_STROB;
    logic              RAM_EN_R;
    logic              RAM_EN_WR;
    logic              Wr;
    logic              ADDR_EN;
    logic              ADDR_RST;
    logic              LAY_EN;
    logic              LAST_LAY;
    logic [ButtWL-1:0] BUT_IDX;
    logic [LayWL-1:0]  LAY_IDX;

    modport slave (
        input  EN, START, N_LAY,
        output BUSY, DONE, ERR, BUT_STROB, RAM_EN_R, RAM_EN_WR, Wr,
               ADDR_EN, ADDR_RST, LAY_EN, LAST_LAY, BUT_IDX, LAY_IDX
    );

    modport master (
        output EN, START, N_LAY,
        input  BUSY, DONE, ERR, BUT_STROB, RAM_EN_R, RAM_EN_WR, Wr,
               ADDR_EN, ADDR_RST, LAY_EN, LAST_LAY, BUT_IDX, LAY_IDX
    );
endinterface

// File: rtl/control_unit_fft_iter_lat.sv
// Sequencer for an in-place iterative radix-2 FFT: per butterfly it issues a read,
// waits BUT_LAT cycles for the datapath, then writes back; size is chosen at START.
module control_unit_fft_iter_lat #(
    parameter int MAX_LAYERS = 10,
    parameter int LayWL      = 4,
    parameter int ButtWL     = 9,
    parameter int BUT_LAT    = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    control_unit_fft_iter_lat_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LAT,
        S_WRITE,
        S_FIN
    } state_t;

    localparam logic [3:0] LAT_LAST = (BUT_LAT > 0) ? 4'(BUT_LAT - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [ButtWL-1:0] but_idx_q, but_idx_d;
    logic [LayWL-1:0]  lay_idx_q, lay_idx_d;
    logic [LayWL-1:0]  nl_q, nl_d;
    logic [ButtWL-1:0] bmax_q, bmax_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;
    logic              last_lay_q, last_lay_d;

    logic n_legal;
    logic layer_end;
    logic final_layer;
    logic fire;
    logic wr_fire;

    // Index of the last butterfly in a layer of an N = 2^n point transform.
    function automatic logic [ButtWL-1:0] bmax_of(input logic [LayWL-1:0] n);
        logic [ButtWL:0] pw;
        pw = (ButtWL + 1)'(1) << (n - LayWL'(1));
        return ButtWL'(pw - (ButtWL + 1)'(1));
    endfunction

    assign n_legal     = (bus.N_LAY != '0) && (bus.N_LAY <= LayWL'(MAX_LAYERS));
    assign layer_end   = (but_idx_q == bmax_q);
    assign final_layer = (lay_idx_q == nl_q - LayWL'(1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            but_idx_q  <= '0;
            lay_idx_q  <= '0;
            nl_q       <= '0;
            bmax_q     <= '0;
            lat_cnt_q  <= '0;
            last_lay_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            but_idx_q  <= but_idx_d;
            lay_idx_q  <= lay_idx_d;
            nl_q       <= nl_d;
            bmax_q     <= bmax_d;
            lat_cnt_q  <= lat_cnt_d;
            last_lay_q <= last_lay_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        but_idx_d = but_idx_q;
        lay_idx_d = lay_idx_q;
        nl_d      = nl_q;
        bmax_d    = bmax_q;
        lat_cnt_d = lat_cnt_q;

        // With EN low every register simply holds, which freezes the whole schedule.
        if (bus.EN) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.START && n_legal) begin
                        nl_d    = bus.N_LAY;
                        bmax_d  = bmax_of(bus.N_LAY);
                        state_d = S_READ;
                    end
                end
                S_READ: begin
                    lat_cnt_d = '0;
                    state_d   = (BUT_LAT > 0) ? S_LAT : S_WRITE;
                end
                S_LAT: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        state_d = S_WRITE;
                    end else begin
                        lat_cnt_d = lat_cnt_q + 4'd1;
                    end
                end
                S_WRITE: begin
                    if (!layer_end) begin
                        but_idx_d = but_idx_q + ButtWL'(1);
                        state_d   = S_READ;
                    end else if (!final_layer) begin
                        but_idx_d = '0;
                        lay_idx_d = lay_idx_q + LayWL'(1);
                        state_d   = S_READ;
                    end else begin
                        state_d = S_FIN;
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Indices read as zero whenever the sequencer rests in IDLE.
        if (state_d == S_IDLE) begin
            but_idx_d = '0;
            lay_idx_d = '0;
        end

        last_lay_d = ((state_d == S_READ) || (state_d == S_LAT) || (state_d == S_WRITE)) &&
                     (lay_idx_d == nl_d - LayWL'(1));
    end

    // Pulses are suppressed on frozen cycles and on the reset cycle itself.
    assign fire    = bus.EN && !RST;
    assign wr_fire = fire && (state_q == S_WRITE);

    always_comb begin
        bus.BUSY      = (state_q != S_IDLE);
        bus.ADDR_RST  = (state_q == S_IDLE);
        bus.BUT_STROB = fire && (state_q == S_READ);
        bus.RAM_EN_R  = fire && (state_q == S_READ);
        bus.RAM_EN_WR = wr_fire;
        bus.Wr        = wr_fire;
        bus.ADDR_EN   = wr_fire;
        bus.LAY_EN    = wr_fire && layer_end && !final_layer;
        bus.DONE      = fire && (state_q == S_FIN);
        bus.ERR       = fire && (state_q == S_IDLE) && bus.START && !n_legal;
        bus.LAST_LAY  = last_lay_q;
        bus.BUT_IDX   = but_idx_q;
        bus.LAY_IDX   = lay_idx_q;
    end

endmodule

// File: tb/tb_control_unit_fft_iter_lat.sv
// Bench for the FFT sequencer: two instances (latency 0 and 2) share one stimulus
// stream and are compared every cycle against a schedule-based reference model.
module tb_control_unit_fft_iter_lat;

    localparam int MAXL = 10;
    localparam int LW   = 4;
    localparam int BW   = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_r   = 1'b1;
    logic          en_r    = 1'b0;
    logic          start_r = 1'b0;
    logic [LW-1:0] nlay_r  = '0;

    control_unit_fft_iter_lat_if #(.LayWL(LW), .ButtWL(BW)) ifa ();
    control_unit_fft_iter_lat_if #(.LayWL(LW), .ButtWL(BW)) ifb ();

    assign ifa.EN = en_r;
    assign ifa.START = start_r;
    assign ifa.N_LAY = nlay_r;
    assign ifb.EN = en_r;
    assign ifb.START = start_r;
    assign ifb.N_LAY = nlay_r;

    control_unit_fft_iter_lat #(.MAX_LAYERS(MAXL), .LayWL(LW), .ButtWL(BW), .BUT_LAT(0)) dut0 (
        .CLK(clk), .RST(rst_r), .bus(ifa));
    control_unit_fft_iter_lat #(.MAX_LAYERS(MAXL), .LayWL(LW), .ButtWL(BW), .BUT_LAT(2)) dut2 (
        .CLK(clk), .RST(rst_r), .bus(ifb));

    // One entry per enabled cycle of a transform: 0 read, 1 latency wait, 2 write, 3 finish.
    typedef struct packed {
        logic [1:0]    kind;
        logic [BW-1:0] b;
        logic [LW-1:0] l;
        logic          last;
        logic          layen;
    } ph_t;

    ph_t q0[$];
    ph_t q1[$];

    typedef struct {
        int n;
        int gap_at;
        int gap_len;
        int busy0;
        int busy2;
        int wr;
        int layen;
        int done;
        int err;
    } vec_t;

    vec_t tbl[8];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int busy_n[2];
    int wr_n[2];
    int layen_n[2];
    int done_n[2];
    int err_n[2];
    int lastwr_n[2];

    function automatic logic legal(input logic [LW-1:0] n);
        return (n >= 1) && (n <= MAXL);
    endfunction

    function automatic logic [23:0] act(input int k);
        if (k == 0)
            return {ifa.BUSY, ifa.DONE, ifa.ERR, ifa.BUT_STROB, ifa.RAM_EN_R, ifa.RAM_EN_WR,
                    ifa.Wr, ifa.ADDR_EN, ifa.ADDR_RST, ifa.LAY_EN, ifa.LAST_LAY,
                    ifa.BUT_IDX, ifa.LAY_IDX};
        return {ifb.BUSY, ifb.DONE, ifb.ERR, ifb.BUT_STROB, ifb.RAM_EN_R, ifb.RAM_EN_WR,
                ifb.Wr, ifb.ADDR_EN, ifb.ADDR_RST, ifb.LAY_EN, ifb.LAST_LAY,
                ifb.BUT_IDX, ifb.LAY_IDX};
    endfunction

    function automatic logic [23:0] expv(input int k);
        ph_t  h;
        logic idle, g, rd, wr, dn, er;
        idle = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
        h    = '0;
        if (!idle) h = (k == 0) ? q0[0] : q1[0];
        g  = en_r && !rst_r;
        rd = g && !idle && (h.kind == 2'd0);
        wr = g && !idle && (h.kind == 2'd2);
        dn = g && !idle && (h.kind == 2'd3);
        er = g && idle && start_r && !legal(nlay_r);
        return {!idle, dn, er, rd, rd, wr, wr, wr, idle, wr && h.layen, h.last, h.b, h.l};
    endfunction

    task automatic push(input int k, input ph_t p);
        if (k == 0) q0.push_back(p);
        else        q1.push_back(p);
    endtask

    // Whole-transform schedule: layers outer, butterflies inner, then one finish cycle.
    task automatic build(input int k, input int n);
        int lat, bmax;
        lat  = (k == 0) ? 0 : 2;
        bmax = (1 << (n - 1)) - 1;
        for (int l = 0; l < n; l++) begin
            for (int b = 0; b <= bmax; b++) begin
                push(k, '{2'd0, BW'(b), LW'(l), l == n - 1, 1'b0});
                for (int t = 0; t < lat; t++) push(k, '{2'd1, BW'(b), LW'(l), l == n - 1, 1'b0});
                push(k, '{2'd2, BW'(b), LW'(l), l == n - 1, (b == bmax) && (l < n - 1)});
            end
        end
        push(k, '{2'd3, BW'(bmax), LW'(n - 1), 1'b0, 1'b0});
    endtask

    task automatic advance(input int k);
        if (rst_r) begin
            if (k == 0) q0.delete(); else q1.delete();
        end else if (en_r) begin
            if ((k == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                if (start_r && legal(nlay_r)) build(k, int'(nlay_r));
            end else begin
                if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic clear_tallies();
        for (int k = 0; k < 2; k++) begin
            busy_n[k] = 0; wr_n[k] = 0; layen_n[k] = 0;
            done_n[k] = 0; err_n[k] = 0; lastwr_n[k] = 0;
        end
    endtask

    task automatic step(input logic e, input logic s, input logic [LW-1:0] n, input logic r);
        logic [23:0] a, x;
        en_r = e; start_r = s; nlay_r = n; rst_r = r;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            a = act(k);
            x = expv(k);
            checks++;
            if (a !== x) begin
                failures++;
                $display("FAIL trace dut%0d cyc=%0d got=%h expected=%h", k, cyc, a, x);
            end
            busy_n[k]  += int'(a[23]);
            done_n[k]  += int'(a[22]);
            err_n[k]   += int'(a[21]);
            wr_n[k]    += int'(a[17]);
            layen_n[k] += int'(a[14]);
            lastwr_n[k] += int'(a[17] && a[13]);
        end
        @(posedge clk);
        advance(0);
        advance(1);
        cyc++;
        #1;
    endtask

    // One transform: START in cycle 0, optional EN-low gap, optional extra START pulses.
    task automatic run_scn(input int n, input int gap_at, input int gap_len, input int sp_until);
        int c;
        step(1'b1, 1'b1, LW'(n), 1'b0);
        c = 1;
        while (((q0.size() != 0) || (q1.size() != 0)) && c < 30000) begin
            step(!((c >= gap_at) && (c < gap_at + gap_len)),
                 (c < sp_until) && (c % 2 == 0), LW'(5), 1'b0);
            c++;
        end
        if (c >= 30000) chk("run_timeout", c, 0);
        step(1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        tbl[0] = '{3, 0, 0, 25, 49, 12, 2, 1, 0};
        tbl[1] = '{2, 0, 0, 9, 17, 4, 1, 1, 0};
        tbl[2] = '{1, 0, 0, 3, 5, 1, 0, 1, 0};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[4] = '{11, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[5] = '{3, 6, 5, 30, 54, 12, 2, 1, 0};
        tbl[6] = '{4, 0, 0, 65, 129, 32, 3, 1, 0};
        tbl[7] = '{10, 0, 0, 10241, 20481, 5120, 9, 1, 0};

        repeat (2) @(posedge clk);
        #1;
        clear_tallies();
        step(1'b1, 1'b0, '0, 1'b0);
        chk("reset_busy", int'(ifa.BUSY), 0);
        chk("reset_addr_rst", int'(ifb.ADDR_RST), 1);

        foreach (tbl[i]) begin
            clear_tallies();
            run_scn(tbl[i].n, tbl[i].gap_at, tbl[i].gap_len, 0);
            chk($sformatf("v%0d_busy_lat0", i), busy_n[0], tbl[i].busy0);
            chk($sformatf("v%0d_busy_lat2", i), busy_n[1], tbl[i].busy2);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("v%0d_wr_d%0d", i, k), wr_n[k], tbl[i].wr);
                chk($sformatf("v%0d_layen_d%0d", i, k), layen_n[k], tbl[i].layen);
                chk($sformatf("v%0d_done_d%0d", i, k), done_n[k], tbl[i].done);
                chk($sformatf("v%0d_err_d%0d", i, k), err_n[k], tbl[i].err);
                chk($sformatf("v%0d_lastwr_d%0d", i, k), lastwr_n[k],
                    tbl[i].err ? 0 : (1 << (tbl[i].n - 1)));
            end
        end

        // Reset landing on a layer-1 write, then a single-butterfly transform.
        clear_tallies();
        step(1'b1, 1'b1, LW'(3), 1'b0);
        for (int c = 0; c < 200; c++) begin
            if ((q0.size() != 0) && (q0[0].kind == 2'd2) && (q0[0].l == 1)) break;
            step(1'b1, 1'b0, '0, 1'b0);
        end
        chk("rst_target_reached", int'((q0.size() != 0) && (q0[0].l == 1)), 1);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("rst_busy", int'(ifa.BUSY), 0);
        chk("rst_addr_rst", int'(ifa.ADDR_RST), 1);
        chk("rst_but_idx", int'(ifa.BUT_IDX), 0);
        chk("rst_lay_idx", int'(ifa.LAY_IDX), 0);
        chk("rst_busy_lat2", int'(ifb.BUSY), 0);
        clear_tallies();
        run_scn(1, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("post_rst_wr_d%0d", k), wr_n[k], 1);
            chk($sformatf("post_rst_lastwr_d%0d", k), lastwr_n[k], 1);
            chk($sformatf("post_rst_done_d%0d", k), done_n[k], 1);
        end

        // START hammered while busy must not restart the N=4 transform.
        clear_tallies();
        run_scn(2, 0, 0, 9);
        chk("restart_busy_lat0", busy_n[0], 9);
        chk("restart_busy_lat2", busy_n[1], 17);
        chk("restart_done_d0", done_n[0], 1);
        chk("restart_done_d1", done_n[1], 1);

        // Randomised traffic against the schedule model, including resets and bad sizes.
        for (int c = 0; c < 3000; c++) begin
            logic [LW-1:0] n;
            n = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(11, 15)) : LW'($urandom_range(0, 4));
            step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, n,
                 $urandom_range(0, 199) == 0);
        end
        for (int c = 0; c < 2000; c++) begin
            if ((q0.size() == 0) && (q1.size() == 0)) break;
            step(1'b1, 1'b0, '0, 1'b0);
        end
        step(1'b1, 1'b0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit_fft_iter_lat.md
Name: control_unit_fft_iter_lat

Overview:
- Sequencer for the in-place iterative radix-2 FFT datapath. Drives RAM read/write strobes, the butterfly strobe, the address-generator enable/reset and layer indices.
- Successor to the fixed two-cycle-per-butterfly controller, with three additions:
  - FFT size is selected at run time (layer count sampled on START).
  - Butterfly pipeline latency is parametrised.
  - The block reports explicit butterfly/layer indices, a DONE pulse and a bad-size error.

Parameters:
- MAX_LAYERS, 10, largest supported log2(N); legal runtime sizes are 1..MAX_LAYERS.
- LayWL, 4, layer counter width; must satisfy 2^LayWL > MAX_LAYERS.
- ButtWL, 9, butterfly counter width; must satisfy 2^ButtWL >= 2^(MAX_LAYERS-1).
- BUT_LAT, 2, cycles between read strobe and write strobe minus one (datapath latency); range 0..15.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  global advance enable; when 0, FSM, counters and latency timer hold, and strobe outputs are forced 0.
- START  in  1  start request; sampled only in IDLE with EN=1.
- N_LAY  in  LayWL  requested layer count log2(N); sampled on accepted START.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse on completion.
- ERR  out  1  one-cycle pulse when START carries an illegal N_LAY.
- BUT_STROB  out  1  butterfly input-capture strobe.
- RAM_EN_R  out  1  RAM read enable.
- RAM_EN_WR  out  1  RAM write-port enable.
- Wr  out  1  write strobe (equal to RAM_EN_WR).
- ADDR_EN  out  1  address generator advance.
- ADDR_RST  out  1  address generator reset.
- LAY_EN  out  1  one-cycle pulse when a layer finishes (not after the final layer).
- LAST_LAY  out  1  high while the final layer is processed.
- BUT_IDX  out  ButtWL  current butterfly index within layer.
- LAY_IDX  out  LayWL  current layer index, 0-based.

Behaviour:
- Reset (RST=1 at edge, any state, including mid-transform):
  - State goes to IDLE; all counters go to 0.
  - BUSY, DONE, ERR, LAY_EN and LAST_LAY are 0; ADDR_RST is 1.
  - No write strobe is issued on the reset cycle.
- States: IDLE, READ, LAT, WRITE, FIN.
- IDLE:
  - ADDR_RST=1 and counters are held at 0.
  - START with 1<=N_LAY<=MAX_LAYERS: latch nl=N_LAY, latch bmax=2^(nl-1)-1, go to READ.
  - START with an illegal N_LAY (0 or >MAX_LAYERS): ERR=1 for one cycle, stay in IDLE.
- READ (one cycle): BUT_STROB=1, RAM_EN_R=1. Next state is LAT if BUT_LAT>0, otherwise WRITE.
- LAT: the timer counts BUT_LAT cycles, then the FSM goes to WRITE. No strobes are asserted.
- WRITE (one cycle): Wr=1, RAM_EN_WR=1, ADDR_EN=1. Counters update at the end of this cycle:
  - If BUT_IDX<bmax: BUT_IDX+1, then READ.
  - Otherwise, if LAY_IDX<nl-1: BUT_IDX=0, LAY_IDX+1, LAY_EN=1 in this WRITE cycle, then READ.
  - Otherwise: go to FIN.
- FIN (one cycle): DONE=1, BUSY=1, then IDLE.
- LAST_LAY is registered: it is 1 while LAY_IDX==nl-1 and state is READ, LAT or WRITE, and 0 otherwise.
- Timing:
  - Each butterfly takes 2+BUT_LAT enabled cycles.
  - Busy duration = nl * 2^(nl-1) * (2+BUT_LAT) + 1 enabled cycles (includes FIN).
  - The first READ occurs in the cycle after the accepting START edge.
- START while BUSY is ignored. N_LAY changes while BUSY have no effect.
- EN=0 mid-operation:
  - The operation is frozen; pulses are not repeated or lost.
  - The pending strobe is asserted in the first EN=1 cycle.
- nl=1 case: bmax=0, so there is one butterfly, LAST_LAY is 1 throughout, and LAY_EN never fires.

Test Plan:
- BUT_LAT=0, START with N_LAY=3:
  - BUSY for 25 cycles.
  - 12 Wr pulses.
  - LAY_EN pulses on write #4 and write #8.
  - LAST_LAY high for writes 9–12.
  - DONE one cycle after write #12, then IDLE.
- BUT_LAT=2, N_LAY=2:
  - Read→write spacing is 3 cycles.
  - 4 butterflies take 16 cycles, plus FIN, for 17 BUSY cycles.
  - BUT_IDX sequence is 0,1,0,1; LAY_IDX sequence is 0,0,1,1.
- START with N_LAY=0, and separately with N_LAY=MAX_LAYERS+1:
  - ERR pulses once.
  - BUSY stays 0 and no strobes are issued.
- N_LAY=3, EN held low for 5 cycles during LAT of butterfly 2:
  - Outputs hold.
  - Total Wr count is still 12.
  - DONE is delayed by exactly 5 cycles.
- RST asserted during the WRITE of layer 1:
  - Next cycle: IDLE, BUSY=0, ADDR_RST=1, indices 0.
  - A new START with N_LAY=1 completes with exactly 1 Wr and LAST_LAY=1.
- START pulsed repeatedly during an N_LAY=2 run:
  - No restart; DONE pulses exactly once.
